// File: rtl/alu_seq_if.sv
// Operand bus and result handshake between alu_seq and its producer/consumer.
// The master side supplies operands and acknowledges results.
// The slave side is the sequencing stage itself.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
) ();

  // Operand transfer: one word moves on a cycle with bus_valid & bus_ready
  logic [WIDTH-1:0] bus_in;
  logic             bus_valid;
  logic             bus_ready;

  // Result hand-back: result is held while result_valid is high
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ack;

  modport master (
    output bus_in,
    output bus_valid,
    output result_ack,
    input  bus_ready,
    input  result,
    input  result_valid
  );

  modport slave (
    input  bus_in,
    input  bus_valid,
    input  result_ack,
    output bus_ready,
    output result,
    output result_valid
  );

endinterface

// File: rtl/alu_seq.sv
// Sequencing stage around a 16-bit combinational ALU.
// Takes an operation request, collects operand A and (for binary ops) operand B
// over the shared bus, lets the ALU settle for one cycle, then captures the result
// and flags and holds them until the consumer acknowledges.
// The carry flag is fed back to the ALU so multi-word add/sub chains work.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,

  // Operation request
  input  logic             start,
  input  logic [4:0]       op_f,
  input  logic             op_fsel,
  input  logic             op_csel,
  input  logic             op_ucin,

  // Operand bus and result handshake
  alu_seq_if.slave         bus,

  // ALU drive
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_f,
  output logic             alu_fsel,
  output logic             alu_csel,
  output logic             alu_ucin,
  output logic             alu_fcin,

  // ALU response
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_zout,

  // Status
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             busy
);

  // ALU function codes this stage needs to recognise (logic/arith unit only)
  localparam logic [4:0] FnPassA = 5'b00000;
  localparam logic [4:0] FnNot   = 5'b00001;
  localparam logic [4:0] FnAdd   = 5'b10010;
  localparam logic [4:0] FnSub   = 5'b01100;

  typedef enum logic [2:0] {
    StIdle,
    StGetA,
    StGetB,
    StExec,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [4:0]       alu_f_q, alu_f_d;
  logic             alu_fsel_q, alu_fsel_d;
  logic             alu_csel_q, alu_csel_d;
  logic             alu_ucin_q, alu_ucin_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             bus_ready;
  logic             xfer;
  logic             op_unary;
  logic             op_sets_carry;

  // Decode the latched operation: unary ops skip GET_B, only ADD/SUB touch the carry
  always_comb begin
    op_unary      = 1'b0;
    op_sets_carry = 1'b0;
    if (!alu_fsel_q) begin
      op_unary      = (alu_f_q == FnPassA) || (alu_f_q == FnNot);
      op_sets_carry = (alu_f_q == FnAdd) || (alu_f_q == FnSub);
    end
  end

  // Handshake: the bus is only open while collecting operands
  always_comb begin
    bus_ready = (state_q == StGetA) || (state_q == StGetB);
    xfer      = bus_ready && bus.bus_valid;
  end

  // Next-state and register-update logic
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_f_d    = alu_f_q;
    alu_fsel_d = alu_fsel_q;
    alu_csel_d = alu_csel_q;
    alu_ucin_d = alu_ucin_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          alu_f_d    = op_f;
          alu_fsel_d = op_fsel;
          alu_csel_d = op_csel;
          alu_ucin_d = op_ucin;
          // Unary ops never load B, so clear it to keep the ALU input defined
          alu_b_d    = '0;
          state_d    = StGetA;
        end
      end

      StGetA: begin
        if (xfer) begin
          alu_a_d = bus.bus_in;
          state_d = op_unary ? StExec : StGetB;
        end
      end

      StGetB: begin
        if (xfer) begin
          alu_b_d = bus.bus_in;
          state_d = StExec;
        end
      end

      StExec: begin
        result_d = alu_y;
        zero_d   = alu_zout;
        if (op_sets_carry) begin
          carry_d = alu_cout;
        end
        state_d = StDone;
      end

      StDone: begin
        // start is deliberately not looked at here, even alongside result_ack
        if (bus.result_ack) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_f_q    <= '0;
      alu_fsel_q <= 1'b0;
      alu_csel_q <= 1'b0;
      alu_ucin_q <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_f_q    <= alu_f_d;
      alu_fsel_q <= alu_fsel_d;
      alu_csel_q <= alu_csel_d;
      alu_ucin_q <= alu_ucin_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
    end
  end

  // Output drive
  always_comb begin
    bus.bus_ready    = bus_ready;
    bus.result       = result_q;
    bus.result_valid = (state_q == StDone);
    alu_a            = alu_a_q;
    alu_b            = alu_b_q;
    alu_f            = alu_f_q;
    alu_fsel         = alu_fsel_q;
    alu_csel         = alu_csel_q;
    alu_ucin         = alu_ucin_q;
    // Direct feedback so csel=1 picks up the carry of the previous ADD/SUB
    alu_fcin         = carry_q;
    carry_flag       = carry_q;
    zero_flag        = zero_q;
    busy             = (state_q != StIdle);
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a small ALU fixture closes the loop, a vector table
// covers the main operations and a few hand-written sequences cover reset and DONE.
module tb_alu_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   op_f;
  logic         op_fsel;
  logic         op_csel;
  logic         op_ucin;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [4:0]   alu_f;
  logic         alu_fsel;
  logic         alu_csel;
  logic         alu_ucin;
  logic         alu_fcin;
  logic [W-1:0] alu_y;
  logic         alu_cout;
  logic         alu_zout;
  logic         carry_flag;
  logic         zero_flag;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_f       (op_f),
    .op_fsel    (op_fsel),
    .op_csel    (op_csel),
    .op_ucin    (op_ucin),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_fsel   (alu_fsel),
    .alu_csel   (alu_csel),
    .alu_ucin   (alu_ucin),
    .alu_fcin   (alu_fcin),
    .alu_y      (alu_y),
    .alu_cout   (alu_cout),
    .alu_zout   (alu_zout),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ALU fixture: carry out is 0 for every non-arithmetic op
  logic         alu_cin;
  logic [W:0]   alu_sum;
  always_comb begin
    alu_cin  = alu_csel ? alu_fcin : alu_ucin;
    alu_sum  = '0;
    alu_y    = alu_a;
    alu_cout = 1'b0;
    if (alu_fsel) begin
      case (alu_f)
        5'b00001: alu_y = alu_a << alu_b[3:0];
        5'b00010: alu_y = alu_a >> alu_b[3:0];
        default:  alu_y = alu_a;
      endcase
    end else begin
      case (alu_f)
        5'b00000: alu_y = alu_a;
        5'b00001: alu_y = ~alu_a;
        5'b10010: begin
          alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
          alu_y    = alu_sum[W-1:0];
          alu_cout = alu_sum[W];
        end
        5'b01100: begin
          alu_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, alu_cin};
          alu_y    = alu_sum[W-1:0];
          alu_cout = alu_sum[W];
        end
        default:  alu_y = alu_a & alu_b;
      endcase
    end
    alu_zout = (alu_y == '0);
  end

  typedef struct {
    logic [4:0]   f;
    logic         fsel;
    logic         csel;
    logic         ucin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           stall;
    logic [W-1:0] y;
    logic         c;
    logic         z;
    logic         fcin;
    int           lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation and feed operands until result_valid; lat counts from start cycle 0
  task automatic run_to_done(input vec_t v, output int lat);
    int   sent;
    int   stall;
    logic xfer;
    @(posedge clk); #1;
    start   = 1'b1;
    op_f    = v.f;
    op_fsel = v.fsel;
    op_csel = v.csel;
    op_ucin = v.ucin;
    @(posedge clk); #1;
    start = 1'b0;
    check("fcin", 32'(alu_fcin), 32'(v.fcin));
    lat   = 1;
    sent  = 0;
    stall = v.stall;
    while (!bus.result_valid && lat < 100) begin
      bus.bus_valid = 1'b0;
      if (bus.bus_ready) begin
        if (sent == 1 && stall > 0) begin
          stall--;
          check("busy_stall", 32'(busy), 32'd1);
        end else begin
          bus.bus_in    = (sent == 0) ? v.a : v.b;
          bus.bus_valid = 1'b1;
        end
      end
      xfer = bus.bus_ready && bus.bus_valid;
      @(posedge clk); #1;
      if (xfer) sent++;
      lat++;
    end
    bus.bus_valid = 1'b0;
  endtask

  initial begin
    int   lat;
    vec_t v;

    //          f         fsel  csel  ucin  a         b        stall y        c     z     fcin lat
    vecs[0] = '{5'b10010, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0001, 0, 16'h1235, 1'b0, 1'b0, 1'b0, 4};
    vecs[1] = '{5'b10010, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 4};
    vecs[2] = '{5'b10010, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0001, 0, 16'h0003, 1'b0, 1'b0, 1'b1, 4};
    vecs[3] = '{5'b01100, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0003, 0, 16'h0002, 1'b1, 1'b0, 1'b0, 4};
    vecs[4] = '{5'b00001, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0000, 0, 16'hFF00, 1'b1, 1'b0, 1'b1, 3};
    vecs[5] = '{5'b00001, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0013, 5, 16'h0008, 1'b1, 1'b0, 1'b1, 9};
    vecs[6] = '{5'b00000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 16'h0000, 1'b1, 1'b1, 1'b1, 3};

    reset          = 1'b1;
    start          = 1'b0;
    op_f           = '0;
    op_fsel        = 1'b0;
    op_csel        = 1'b0;
    op_ucin        = 1'b0;
    bus.bus_in     = '0;
    bus.bus_valid  = 1'b0;
    bus.result_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_busy",   32'(busy),             32'd0);
    check("rst_ready",  32'(bus.bus_ready),    32'd0);
    check("rst_valid",  32'(bus.result_valid), 32'd0);
    check("rst_result", 32'(bus.result),       32'd0);
    check("rst_carry",  32'(carry_flag),       32'd0);
    check("rst_zero",   32'(zero_flag),        32'd0);
    check("rst_alu_a",  32'(alu_a),            32'd0);

    for (int i = 0; i < 7; i++) begin
      run_to_done(vecs[i], lat);
      check($sformatf("v%0d_latency", i), 32'(lat),              32'(vecs[i].lat));
      check($sformatf("v%0d_result", i),  32'(bus.result),       32'(vecs[i].y));
      check($sformatf("v%0d_carry", i),   32'(carry_flag),       32'(vecs[i].c));
      check($sformatf("v%0d_zero", i),    32'(zero_flag),        32'(vecs[i].z));
      bus.result_ack = 1'b1;
      @(posedge clk); #1;
      bus.result_ack = 1'b0;
      check($sformatf("v%0d_valid_drop", i), 32'(bus.result_valid), 32'd0);
      check($sformatf("v%0d_idle", i),       32'(busy),             32'd0);
      check($sformatf("v%0d_held", i),       32'(bus.result),       32'(vecs[i].y));
    end

    // Reset mid-operation in GET_B while the carry flag is set
    check("pre_rst_carry", 32'(carry_flag), 32'd1);
    start   = 1'b1;
    op_f    = 5'b10010;
    op_fsel = 1'b0;
    op_csel = 1'b0;
    op_ucin = 1'b0;
    @(posedge clk); #1;
    start         = 1'b0;
    bus.bus_in    = 16'h4321;
    bus.bus_valid = 1'b1;
    @(posedge clk); #1;
    bus.bus_valid = 1'b0;
    check("getb_ready", 32'(bus.bus_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mrst_busy",   32'(busy),             32'd0);
    check("mrst_ready",  32'(bus.bus_ready),    32'd0);
    check("mrst_carry",  32'(carry_flag),       32'd0);
    check("mrst_result", 32'(bus.result),       32'd0);
    check("mrst_valid",  32'(bus.result_valid), 32'd0);
    check("mrst_alu_a",  32'(alu_a),            32'd0);
    check("mrst_alu_f",  32'(alu_f),            32'd0);

    // DONE ignores start, including when it coincides with result_ack
    v = '{5'b10010, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0003, 0, 16'h0005, 1'b0, 1'b0, 1'b0, 4};
    run_to_done(v, lat);
    check("d_latency", 32'(lat),        32'd4);
    check("d_result",  32'(bus.result), 32'h5);
    for (int i = 0; i < 3; i++) begin
      start = (i != 1);
      @(posedge clk); #1;
      check($sformatf("d_hold%0d_valid", i),  32'(bus.result_valid), 32'd1);
      check($sformatf("d_hold%0d_result", i), 32'(bus.result),       32'h5);
    end
    start          = 1'b1;
    bus.result_ack = 1'b1;
    @(posedge clk); #1;
    start          = 1'b0;
    bus.result_ack = 1'b0;
    check("d_ack_valid", 32'(bus.result_valid), 32'd0);
    check("d_ack_busy",  32'(busy),             32'd0);
    @(posedge clk); #1;
    check("d_no_new_op", 32'(busy),             32'd0);
    check("d_no_ready",  32'(bus.bus_ready),    32'd0);
    check("d_kept",      32'(bus.result),       32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequencing stage directly upstream and downstream of the 16-bit combinational ALU.
- Accepts an operation request, then collects operand A and operand B (when needed) one word at a time over a shared 16-bit data bus with a valid/ready handshake.
- Drives the ALU inputs, captures its result, and holds the carry and zero flags.
- The carry flag register feeds back into the ALU's flag-carry input, so multi-word add/sub chains work across operations.

Parameters:
- WIDTH, 16, data/operand width; must match the ALU.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a new operation; sampled only in IDLE
- op_f  in  5  ALU function code, latched on accepted start
- op_fsel  in  1  0 = logic/arith unit, 1 = shifter; latched on start
- op_csel  in  1  0 = use op_ucin as carry-in, 1 = use carry flag; latched on start
- op_ucin  in  1  user carry-in; latched on start
- bus_in  in  WIDTH  operand data
- bus_valid  in  1  bus_in holds a valid operand
- bus_ready  out  1  stage accepts an operand this cycle
- alu_a  out  WIDTH  operand A register to ALU
- alu_b  out  WIDTH  operand B register to ALU
- alu_f  out  5  latched op_f
- alu_fsel  out  1  latched op_fsel
- alu_csel  out  1  latched op_csel
- alu_ucin  out  1  latched op_ucin
- alu_fcin  out  1  equals carry_flag
- alu_y  in  WIDTH  ALU result
- alu_cout  in  1  ALU carry out
- alu_zout  in  1  ALU zero out
- result  out  WIDTH  captured result
- result_valid  out  1  result is held and awaiting acknowledge
- result_ack  in  1  consumer takes result
- carry_flag  out  1  carry flag register
- zero_flag  out  1  zero flag register
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, overrides everything, including mid-operation):
  - state = IDLE.
  - All of the following are 0: alu_a, alu_b, alu_f, alu_fsel, alu_csel, alu_ucin, result, carry_flag, zero_flag.
  - result_valid, bus_ready and busy are 0.
- States: IDLE, GET_A, GET_B, EXEC, DONE.
- IDLE:
  - On start: latch the op_* fields, clear alu_b to 0, go to GET_A.
  - No start: stay in IDLE.
- GET_A:
  - bus_ready = 1.
  - On bus_valid & bus_ready: alu_a <= bus_in.
  - Unary ops (op_fsel=0 and op_f equal to 00000 (pass A) or 00001 (NOT)) go to EXEC. All other ops go to GET_B.
  - Without bus_valid, stay in GET_A indefinitely.
- GET_B:
  - bus_ready = 1.
  - On transfer: alu_b <= bus_in, go to EXEC.
- EXEC:
  - One cycle for the ALU to settle. At the end of EXEC: result <= alu_y, zero_flag <= alu_zout.
  - carry_flag <= alu_cout only when op_fsel=0 and op_f is ADD (10010) or SUB (01100). Otherwise carry_flag is unchanged.
  - Go to DONE.
- DONE:
  - result_valid = 1; result and flags are stable.
  - On result_ack: go to IDLE. result_valid drops the following cycle.
  - start is ignored in DONE, even when result_ack is high in the same cycle.
- start is ignored in every state other than IDLE. bus_valid is ignored whenever bus_ready=0.
- alu_fcin is combinationally equal to carry_flag, so an operation with csel=1 uses the flag from the previous ADD/SUB.
- Minimum latency with bus_valid held high: start in cycle 0, A in cycle 1, B in cycle 2, EXEC in cycle 3, result_valid in cycle 4. Unary ops are one cycle shorter.
- result, carry_flag and zero_flag hold their values after returning to IDLE until the next EXEC.
- Shifts use only the low 4 bits of alu_b (ALU behaviour); this stage passes all WIDTH bits unmodified.

Test Plan:
- ADD (f=10010, fsel=0, csel=0, ucin=0), A=0x1234, B=0x0001 -> result 0x1235, carry 0, zero 0, result_valid in cycle 4 after start.
- ADD csel=0 ucin=0, A=0xFFFF, B=0x0001 -> result 0x0000, carry 1, zero 1. Then ADD csel=1, A=0x0001, B=0x0001 -> alu_fcin=1, result 0x0003, carry 0.
- SUB (f=01100) ucin=1, A=0x0005, B=0x0003 -> result 0x0002, carry 1. Then NOT (f=00001) with a single bus transfer A=0x00FF -> result 0xFF00, carry still 1, result_valid in cycle 3.
- Shift left (fsel=1, f=00001), A=0x0001, B=0x0013 -> result 0x0008, carry unchanged. bus_valid held low for 5 cycles in GET_B -> stage waits, busy stays 1.
- Reset asserted in GET_B with carry_flag=1 -> next cycle state IDLE, busy 0, bus_ready 0, carry_flag 0, result 0x0000.
- In DONE, hold result_ack low for 3 cycles while pulsing start -> result_valid stays 1 and start is ignored. Assert result_ack together with start -> IDLE next cycle, no new operation begins.
